// File: rtl/proc_stack_pkg.sv
// Shared definitions for the processor return-address stack slice.
// Holds the PC width, the call/return controller state encoding, the fault
// codes reported to the OS layer and the fixed entry vectors.
package proc_stack_pkg;

    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DEPTH_W   = 10;
    localparam int unsigned DEPTH_MAX = 1023;

    localparam logic [ADDR_W-1:0] INT_VECTOR   = 13'h0010;
    localparam logic [ADDR_W-1:0] FAULT_VECTOR = 13'h0004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        POP   = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_OVF      = 2'd1,
        FLT_UDF      = 2'd2,
        FLT_MISMATCH = 2'd3
    } fault_t;

endpackage

// File: rtl/call_return_unit.sv
// call_return_unit
// Initiator side of the hardware return-address stack. Converts decoded
// call / return / interrupt requests into push/pop commands for the stack
// file, waits one cycle for the stack (which acts on the falling edge of
// Slow_Clock), then loads the resulting next PC. A shadow depth count catches
// overflow and underflow before any command is issued; any stack error raises
// a sticky fault that the OS layer clears with Fault_Ack.
//
// Ports:
//   Slow_Clock   processor clock (this block: posedge, stack: negedge)
//   Reset        asynchronous, active-high
//   Call_Req     decoded call, held while Stall=1
//   Ret_Req      decoded return, held while Stall=1
//   Int_Req      level interrupt request
//   PC           current instruction address
//   Target       call destination
//   Ret_Add      address popped by the stack
//   Err_Out      stack error flag
//   Fault_Ack    OS acknowledge, clears the fault
//   Stack_Enable stack command valid (one cycle per command)
//   Stack_Write  1 = push, 0 = pop
//   NPPC         address to push
//   Next_PC      PC to load
//   PC_Load      one-cycle pulse, PC takes Next_PC
//   Stall        freezes fetch/decode
//   Stack_Fault  sticky fault flag
//   Fault_Code   0 none, 1 overflow, 2 underflow, 3 mismatch
//   Depth        shadow entry count
module call_return_unit #(
    parameter int unsigned       ADDR_W       = proc_stack_pkg::ADDR_W,
    parameter int unsigned       DEPTH_MAX    = proc_stack_pkg::DEPTH_MAX,
    parameter logic [ADDR_W-1:0] INT_VECTOR   = proc_stack_pkg::INT_VECTOR,
    parameter logic [ADDR_W-1:0] FAULT_VECTOR = proc_stack_pkg::FAULT_VECTOR
) (
    input  logic              Slow_Clock,
    input  logic              Reset,
    input  logic              Call_Req,
    input  logic              Ret_Req,
    input  logic              Int_Req,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] Target,
    input  logic [ADDR_W-1:0] Ret_Add,
    input  logic              Err_Out,
    input  logic              Fault_Ack,
    output logic              Stack_Enable,
    output logic              Stack_Write,
    output logic [ADDR_W-1:0] NPPC,
    output logic [ADDR_W-1:0] Next_PC,
    output logic              PC_Load,
    output logic              Stall,
    output logic              Stack_Fault,
    output logic [1:0]        Fault_Code,
    output logic [9:0]        Depth
);

    import proc_stack_pkg::*;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH_MAX);

    state_t              state_q,        state_d;
    logic                stack_enable_q, stack_enable_d;
    logic                stack_write_q,  stack_write_d;
    logic [ADDR_W-1:0]   nppc_q,         nppc_d;
    logic [ADDR_W-1:0]   next_pc_q,      next_pc_d;
    logic                pc_load_q,      pc_load_d;
    logic                stall_q,        stall_d;
    logic                stack_fault_q,  stack_fault_d;
    fault_t              fault_code_q,   fault_code_d;
    logic [DEPTH_W-1:0]  depth_q,        depth_d;
    // PC to load once the push has been confirmed by the stack
    logic [ADDR_W-1:0]   dest_q,         dest_d;

    // Fault entry is shared by the pre-checks and the stack-error paths
    logic                go_fault;
    fault_t              go_code;

    logic                depth_full;
    logic                depth_empty;

    assign depth_full  = (depth_q == DEPTH_FULL);
    assign depth_empty = (depth_q == '0);

    always_comb begin
        state_d        = state_q;
        stack_enable_d = 1'b0;
        stack_write_d  = stack_write_q;
        nppc_d         = nppc_q;
        next_pc_d      = next_pc_q;
        pc_load_d      = 1'b0;
        stall_d        = stall_q;
        stack_fault_d  = stack_fault_q;
        fault_code_d   = fault_code_q;
        depth_d        = depth_q;
        dest_d         = dest_q;
        go_fault       = 1'b0;
        go_code        = FLT_NONE;

        unique case (state_q)
            IDLE: begin
                // The decoder still presents the old request during the
                // PC_Load cycle, so requests are only taken one cycle later.
                if (!pc_load_q) begin
                    if (Int_Req) begin
                        if (depth_full) begin
                            go_fault = 1'b1;
                            go_code  = FLT_OVF;
                        end else begin
                            stack_enable_d = 1'b1;
                            stack_write_d  = 1'b1;
                            nppc_d         = PC;
                            dest_d         = INT_VECTOR;
                            stall_d        = 1'b1;
                            state_d        = PUSH;
                        end
                    end else if (Call_Req) begin
                        if (depth_full) begin
                            go_fault = 1'b1;
                            go_code  = FLT_OVF;
                        end else begin
                            stack_enable_d = 1'b1;
                            stack_write_d  = 1'b1;
                            nppc_d         = PC + ADDR_W'(1);
                            dest_d         = Target;
                            stall_d        = 1'b1;
                            state_d        = PUSH;
                        end
                    end else if (Ret_Req) begin
                        if (depth_empty) begin
                            go_fault = 1'b1;
                            go_code  = FLT_UDF;
                        end else begin
                            stack_enable_d = 1'b1;
                            stack_write_d  = 1'b0;
                            stall_d        = 1'b1;
                            state_d        = POP;
                        end
                    end
                end
            end

            PUSH: begin
                if (Err_Out) begin
                    go_fault = 1'b1;
                    go_code  = FLT_MISMATCH;
                end else begin
                    next_pc_d = dest_q;
                    pc_load_d = 1'b1;
                    depth_d   = depth_q + DEPTH_W'(1);
                    stall_d   = 1'b0;
                    state_d   = IDLE;
                end
            end

            POP: begin
                if (Err_Out) begin
                    go_fault = 1'b1;
                    go_code  = FLT_MISMATCH;
                end else begin
                    next_pc_d = Ret_Add;
                    pc_load_d = 1'b1;
                    depth_d   = depth_q - DEPTH_W'(1);
                    stall_d   = 1'b0;
                    state_d   = IDLE;
                end
            end

            FAULT: begin
                if (Fault_Ack) begin
                    stack_fault_d = 1'b0;
                    fault_code_d  = FLT_NONE;
                    stall_d       = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Depth is left untouched on every fault path
        if (go_fault) begin
            state_d        = FAULT;
            stack_fault_d  = 1'b1;
            fault_code_d   = go_code;
            next_pc_d      = FAULT_VECTOR;
            pc_load_d      = 1'b1;
            stack_enable_d = 1'b0;
            stall_d        = 1'b1;
        end
    end

    always_ff @(posedge Slow_Clock or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            stack_enable_q <= 1'b0;
            stack_write_q  <= 1'b0;
            nppc_q         <= '0;
            next_pc_q      <= '0;
            pc_load_q      <= 1'b0;
            stall_q        <= 1'b0;
            stack_fault_q  <= 1'b0;
            fault_code_q   <= FLT_NONE;
            depth_q        <= '0;
            dest_q         <= '0;
        end else begin
            state_q        <= state_d;
            stack_enable_q <= stack_enable_d;
            stack_write_q  <= stack_write_d;
            nppc_q         <= nppc_d;
            next_pc_q      <= next_pc_d;
            pc_load_q      <= pc_load_d;
            stall_q        <= stall_d;
            stack_fault_q  <= stack_fault_d;
            fault_code_q   <= fault_code_d;
            depth_q        <= depth_d;
            dest_q         <= dest_d;
        end
    end

    assign Stack_Enable = stack_enable_q;
    assign Stack_Write  = stack_write_q;
    assign NPPC         = nppc_q;
    assign Next_PC      = next_pc_q;
    assign PC_Load      = pc_load_q;
    assign Stall        = stall_q;
    assign Stack_Fault  = stack_fault_q;
    assign Fault_Code   = fault_code_q;
    assign Depth        = depth_q;

endmodule

// File: tb/tb_call_return_unit.sv
// Scoreboard bench for call_return_unit. Expected stack commands and PC loads
// are queued when a request is driven; a negedge monitor plays the stack file
// and pops/compares each command and each PC_Load against the queues.
module tb_call_return_unit;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          call_req, ret_req, int_req;
    logic [AW-1:0] pc, target, ret_add;
    logic          err_out, fault_ack;
    logic          stack_enable, stack_write, pc_load, stall, stack_fault;
    logic [AW-1:0] nppc, next_pc;
    logic [1:0]    fault_code;
    logic [9:0]    depth;

    call_return_unit #(
        .ADDR_W      (13),
        .DEPTH_MAX   (1023),
        .INT_VECTOR  (13'h0010),
        .FAULT_VECTOR(13'h0004)
    ) dut (
        .Slow_Clock  (clk),
        .Reset       (rst),
        .Call_Req    (call_req),
        .Ret_Req     (ret_req),
        .Int_Req     (int_req),
        .PC          (pc),
        .Target      (target),
        .Ret_Add     (ret_add),
        .Err_Out     (err_out),
        .Fault_Ack   (fault_ack),
        .Stack_Enable(stack_enable),
        .Stack_Write (stack_write),
        .NPPC        (nppc),
        .Next_PC     (next_pc),
        .PC_Load     (pc_load),
        .Stall       (stall),
        .Stack_Fault (stack_fault),
        .Fault_Code  (fault_code),
        .Depth       (depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [9:0]    depth;
        logic          flt;
        logic [1:0]    code;
    } load_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] nppc;
    } cmd_t;

    load_t         load_q[$];
    cmd_t          cmd_q[$];
    logic [AW-1:0] stk[$];      // stack file contents as seen by the monitor
    logic [AW-1:0] exp_ra[$];   // expected return addresses
    int            depth_m;
    int            loads_seen;
    logic          prev_en;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stack file model plus scoreboard comparison
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (stack_enable) begin
                check("en_back2back", {31'd0, prev_en}, 0);
                check("cmd_pending", {31'd0, cmd_q.size() > 0}, 1);
                if (cmd_q.size() > 0) begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    check("cmd_wr", {31'd0, stack_write}, {31'd0, c.wr});
                    if (c.wr) check("cmd_nppc", {19'd0, nppc}, {19'd0, c.nppc});
                end
                if (stack_write) begin
                    if (!err_out) stk.push_back(nppc);
                end else begin
                    ret_add = (stk.size() > 0) ? stk.pop_back() : '0;
                end
            end
            if (pc_load) begin
                loads_seen++;
                check("load_pending", {31'd0, load_q.size() > 0}, 1);
                if (load_q.size() > 0) begin
                    load_t l;
                    l = load_q.pop_front();
                    check("next_pc", {19'd0, next_pc}, {19'd0, l.pc});
                    check("depth", {22'd0, depth}, {22'd0, l.depth});
                    check("stack_fault", {31'd0, stack_fault}, {31'd0, l.flt});
                    check("fault_code", {30'd0, fault_code}, {30'd0, l.code});
                end
            end
            prev_en = stack_enable;
        end
    end

    task automatic exp_call(input logic [AW-1:0] p, input logic [AW-1:0] t);
        logic [AW-1:0] ra;
        ra = p + 13'd1;
        cmd_q.push_back('{1'b1, ra});
        exp_ra.push_back(ra);
        depth_m++;
        load_q.push_back('{t, 10'(depth_m), 1'b0, 2'd0});
    endtask

    task automatic exp_int(input logic [AW-1:0] p);
        cmd_q.push_back('{1'b1, p});
        exp_ra.push_back(p);
        depth_m++;
        load_q.push_back('{13'h0010, 10'(depth_m), 1'b0, 2'd0});
    endtask

    task automatic exp_ret();
        logic [AW-1:0] ra;
        ra = exp_ra.pop_back();
        cmd_q.push_back('{1'b0, 13'd0});
        depth_m--;
        load_q.push_back('{ra, 10'(depth_m), 1'b0, 2'd0});
    endtask

    task automatic exp_fault(input logic [1:0] code);
        load_q.push_back('{13'h0004, 10'(depth_m), 1'b1, code});
    endtask

    // Waits for the next PC_Load (bounded) and checks how many edges it took
    task automatic wait_load(input string tag, input int exp_lat);
        int start;
        int lat;
        start = loads_seen;
        lat   = 0;
        while (loads_seen == start && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {26'd0, stack_enable, stack_write, pc_load, stall,
                              stack_fault, fault_code}, 0);
        check({tag, "_nppc"}, {19'd0, nppc}, 0);
        check({tag, "_npc"}, {19'd0, next_pc}, 0);
        check({tag, "_depth"}, {22'd0, depth}, 0);
    endtask

    task automatic ack_fault(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 1);
        fault_ack = 1'b1;
        @(posedge clk);
        #1;
        fault_ack = 1'b0;
        check({tag, "_clr"}, {29'd0, stack_fault, fault_code}, 0);
        check({tag, "_unstall"}, {31'd0, stall}, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        int_req  = 1'b0;
        err_out  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmd_q.delete();
        load_q.delete();
        stk.delete();
        exp_ra.delete();
        depth_m = 0;
        rst     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; call_req = 0; ret_req = 0; int_req = 0;
        pc = '0; target = '0; ret_add = '0; err_out = 0; fault_ack = 0;
        depth_m = 0; loads_seen = 0; prev_en = 0;
        #1;
        check_zero_outputs("reset");
        do_reset();

        // Basic call then return
        pc = 13'h0100; target = 13'h0200;
        exp_call(pc, target);
        call_req = 1'b1;
        wait_load("call", 3);
        call_req = 1'b0;
        exp_ret();
        ret_req = 1'b1;
        wait_load("ret", 3);
        ret_req = 1'b0;

        // Underflow pre-check
        exp_fault(2'd2);
        ret_req = 1'b1;
        wait_load("udf", 2);
        ret_req = 1'b0;
        ack_fault("udf");

        // Return-address wrap at the top of the address space
        pc = 13'h1FFF; target = 13'h00AA;
        exp_call(pc, target);
        call_req = 1'b1;
        wait_load("wrap_call", 3);
        call_req = 1'b0;
        exp_ret();
        ret_req = 1'b1;
        wait_load("wrap_ret", 3);
        ret_req = 1'b0;

        // Fill to the limit, then one call too many
        for (int i = 0; i < 1023; i++) begin
            pc = 13'(i * 3); target = 13'(i + 13'h0400);
            exp_call(pc, target);
            call_req = 1'b1;
            wait_load("nest", 3);
            call_req = 1'b0;
        end
        exp_fault(2'd1);
        call_req = 1'b1;
        wait_load("ovf", 2);
        call_req = 1'b0;
        check("ovf_depth", {22'd0, depth}, 1023);
        ack_fault("ovf");
        do_reset();

        // Interrupt wins; call and return stay pending and are served after
        pc = 13'h0050; target = 13'h0300;
        exp_int(pc);
        exp_call(pc, target);
        exp_ret();
        int_req = 1'b1; call_req = 1'b1; ret_req = 1'b1;
        wait_load("int", 3);
        int_req = 1'b0;
        wait_load("pend_call", 3);
        call_req = 1'b0;
        wait_load("pend_ret", 3);
        ret_req = 1'b0;

        // Stack error during a push
        pc = 13'h0122; target = 13'h0999;
        cmd_q.push_back('{1'b1, 13'h0123});
        exp_fault(2'd3);
        err_out  = 1'b1;
        call_req = 1'b1;
        wait_load("mm", 3);
        call_req = 1'b0;
        err_out  = 1'b0;
        check("mm_depth", {22'd0, depth}, 1);
        ack_fault("mm");

        // Reset while the pop is in flight
        ret_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_pop");
        do_reset();

        pc = 13'h0700; target = 13'h0800;
        exp_call(pc, target);
        call_req = 1'b1;
        wait_load("post_rst", 3);
        call_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("load_q_left", load_q.size(), 0);
        check("cmd_q_left", cmd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/call_return_unit.md
# call_return_unit

Initiator side of the processor's hardware return-address stack. It turns decoded call, return and interrupt requests into stack push/pop commands (Stack_Enable, Stack_Write, NPPC), waits for the stack to act on the falling edge of Slow_Clock, and loads the resulting next PC. It keeps a shadow depth count so that overflow and underflow are caught before a command is issued. It also raises a sticky fault to the OS layer on any stack error. It sits between the instruction decoder/PC logic and the stack file.

## Interface
Parameters:
- ADDR_W, 13: PC / return-address width.
- DEPTH_MAX, 1023: maximum number of live entries; matches the stack's pointer limit.
- INT_VECTOR, 13'h0010: PC loaded on an interrupt entry.
- FAULT_VECTOR, 13'h0004: PC loaded on a stack fault.

Ports:
- Slow_Clock  in  1  processor clock; this block acts on posedge, the stack on negedge.
- Reset  in  1  asynchronous, active-high; shared with the stack file.
- Call_Req  in  1  decoded call; held by the decoder while Stall=1.
- Ret_Req  in  1  decoded return; held by the decoder while Stall=1.
- Int_Req  in  1  level interrupt request.
- PC  in  ADDR_W  address of the current instruction.
- Target  in  ADDR_W  call destination.
- Ret_Add  in  ADDR_W  popped address from the stack.
- Err_Out  in  1  stack error flag.
- Fault_Ack  in  1  OS acknowledge; clears FAULT.
- Stack_Enable  out  1  stack command valid.
- Stack_Write  out  1  1 = push, 0 = pop.
- NPPC  out  ADDR_W  address to push.
- Next_PC  out  ADDR_W  PC to load.
- PC_Load  out  1  one-cycle pulse; PC takes Next_PC.
- Stall  out  1  freezes fetch/decode.
- Stack_Fault  out  1  sticky fault flag.
- Fault_Code  out  2  0 none, 1 overflow, 2 underflow, 3 mismatch.
- Depth  out  10  shadow entry count.

## Operation
- States: IDLE, PUSH, POP, FAULT.
- All outputs are registered. Reset value of every output is 0, Fault_Code is 0, and the state is IDLE.
- Request priority in IDLE: Int_Req, then Call_Req, then Ret_Req. Lower-priority requests are ignored that cycle; the decoder keeps holding them.
- IDLE + Int_Req:
  - If Depth==DEPTH_MAX: go to FAULT, code 1.
  - Otherwise: Stack_Enable=1, Stack_Write=1, NPPC=PC (resume at the interrupted instruction), Stall=1, go to PUSH. Destination is INT_VECTOR.
- IDLE + Call_Req:
  - Same as interrupt, except NPPC=PC+1, with the sum truncated to ADDR_W (wraps from 13'h1FFF to 0).
  - Destination is Target.
- IDLE + Ret_Req:
  - If Depth==0: go to FAULT, code 2.
  - Otherwise: Stack_Enable=1, Stack_Write=0, Stall=1, go to POP.
- PUSH:
  - If Err_Out=0: Next_PC=destination, PC_Load=1, Depth+1, Stack_Enable=0, Stall=0, go to IDLE.
  - If Err_Out=1: go to FAULT, code 3.
- POP:
  - If Err_Out=0: Next_PC=Ret_Add, PC_Load=1, Depth-1, go to IDLE.
  - If Err_Out=1: go to FAULT, code 3.
- Entering FAULT:
  - Stack_Fault=1, Next_PC=FAULT_VECTOR, PC_Load pulses once, Stack_Enable=0, Stall=1.
  - No stack commands are issued while in FAULT. Depth is unchanged.
- FAULT + Fault_Ack: clear Stack_Fault and Fault_Code, Stall=0, go to IDLE.
- Depth never wraps. The pre-checks make 1024 and -1 unreachable.
- Reset mid-operation: the stack is reset by the same Reset, so Depth=0 remains consistent. A pending command is dropped.

## Timing
- Cycle 0 (posedge): the request is sampled and the command is registered.
- Mid-cycle 0 (negedge): the stack performs the push or pop.
- Cycle 1 (posedge): Err_Out and Ret_Add are sampled, and PC_Load and Next_PC are registered.
- Result: call, return and interrupt each cost exactly one stall cycle. PC_Load is high for one cycle.
- Stack_Enable is high for exactly one cycle per command. It is never asserted in two consecutive cycles.
- Pre-check faults: PC_Load goes high at the posedge after the request, with no stack command issued.
- A new request is accepted at the earliest one cycle after PC_Load.

## Structure
- Shared package proc_stack_pkg holds:
  - ADDR_W.
  - State encoding (IDLE=2'd0, PUSH=2'd1, POP=2'd2, FAULT=2'd3).
  - Fault codes (FLT_NONE, FLT_OVF, FLT_UDF, FLT_MISMATCH).
  - Vector constants.
- Single flat module; no sub-module is warranted. The depth counter is inline.

## Test plan
- Call at PC=13'h0100, Target=13'h0200:
  - Stack sees push of 13'h0101.
  - PC_Load one cycle later with Next_PC=13'h0200, Depth=1.
  - Then Ret_Req: Next_PC=13'h0101, Depth=0.
- Ret_Req with Depth=0: no Stack_Enable; Fault_Code=2, Next_PC=13'h0004. Fault_Ack then returns to IDLE with Stack_Fault=0.
- 1023 nested calls, then one more call: the 1024th raises Fault_Code=1 with no push issued, and Depth stays 1023.
- Int_Req, Call_Req and Ret_Req asserted together at PC=13'h0050:
  - Push of 13'h0050.
  - Next_PC=13'h0010.
  - Call and Ret remain pending and are served after the stall.
- Forced Err_Out=1 during PUSH: Fault_Code=3 and Depth unchanged.
- Reset asserted in the POP state: all outputs are 0 and the state is IDLE immediately; the next call works normally.
